// File: rtl/rs_issue_sched_if.sv
// rs_issue_sched_if: handshake bundle between dispatch/CDB/FU and one
// reservation-station issue scheduler.
//   flush_i            : discard all scheduler entries
//   alloc_*            : dispatch offer (valid/ready) plus decoded payload
//   cdb_en_i/cdb_tag_i : common data bus broadcast used for wakeup
//   issue_*            : selected entry presented to the FU (valid/ready)
//   count_o            : occupied scheduler slots
// master = dispatch/FU side driving the scheduler, slave = the scheduler.
interface rs_issue_sched_if #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 3
);
  logic             flush_i;

  logic             alloc_valid_i;
  logic             alloc_ready_o;
  logic [31:0]      alloc_pc_i;
  logic [31:0]      alloc_inst_i;
  logic [TAG_W-1:0] alloc_prs1_addr_i;
  logic [TAG_W-1:0] alloc_prs2_addr_i;
  logic [TAG_W-1:0] alloc_prd_addr_i;
  logic             alloc_prs1_valid_i;
  logic             alloc_prs2_valid_i;

  logic             cdb_en_i;
  logic [TAG_W-1:0] cdb_tag_i;

  logic             issue_valid_o;
  logic             issue_ready_i;
  logic [31:0]      issue_pc_o;
  logic [31:0]      issue_inst_o;
  logic [TAG_W-1:0] issue_prs1_addr_o;
  logic [TAG_W-1:0] issue_prs2_addr_o;
  logic [TAG_W-1:0] issue_prd_addr_o;

  logic [CNT_W-1:0] count_o;

  modport master (
    output flush_i,
    output alloc_valid_i, alloc_pc_i, alloc_inst_i,
    output alloc_prs1_addr_i, alloc_prs2_addr_i, alloc_prd_addr_i,
    output alloc_prs1_valid_i, alloc_prs2_valid_i,
    output cdb_en_i, cdb_tag_i,
    output issue_ready_i,
    input  alloc_ready_o,
    input  issue_valid_o, issue_pc_o, issue_inst_o,
    input  issue_prs1_addr_o, issue_prs2_addr_o, issue_prd_addr_o,
    input  count_o
  );

  modport slave (
    input  flush_i,
    input  alloc_valid_i, alloc_pc_i, alloc_inst_i,
    input  alloc_prs1_addr_i, alloc_prs2_addr_i, alloc_prd_addr_i,
    input  alloc_prs1_valid_i, alloc_prs2_valid_i,
    input  cdb_en_i, cdb_tag_i,
    input  issue_ready_i,
    output alloc_ready_o,
    output issue_valid_o, issue_pc_o, issue_inst_o,
    output issue_prs1_addr_o, issue_prs2_addr_o, issue_prd_addr_o,
    output count_o
  );
endinterface

// File: rtl/rs_issue_sched.sv
// rs_issue_sched: issue scheduler for one reservation-station class.
// Holds up to NUM_ENTRIES instructions, wakes their sources from CDB
// broadcasts and hands the oldest fully-ready entry to the FU.
// Ports:
//   clk_i   : clock, all state updates on the rising edge
//   reset_i : synchronous active-high reset
//   bus     : rs_issue_sched_if.slave (flush, alloc, CDB, issue, count)
// Optional feature: define RS_SAME_CYCLE_WAKEUP_EN to let a CDB match make
// an entry selectable in the broadcast cycle itself; without it, a woken
// entry is first selectable one cycle later.
module rs_issue_sched #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 5,
  parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input logic            clk_i,
  input logic            reset_i,
  rs_issue_sched_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  typedef logic [IDX_W-1:0] idx_t;

  // Slot control state (reset) and payload (not reset, masked by valid)
  logic [NUM_ENTRIES-1:0] valid_q, rdy1_q, rdy2_q;
  // older_q[j][i] = slot j is older than slot i
  logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
  logic                   lock_q;
  idx_t                   lock_idx_q;

  logic [31:0]      pc_q   [NUM_ENTRIES];
  logic [31:0]      inst_q [NUM_ENTRIES];
  logic [TAG_W-1:0] prs1_q [NUM_ENTRIES];
  logic [TAG_W-1:0] prs2_q [NUM_ENTRIES];
  logic [TAG_W-1:0] prd_q  [NUM_ENTRIES];

  // Wakeup match and select candidates
  logic [NUM_ENTRIES-1:0] hit1, hit2, sel_rdy1, sel_rdy2, cand;

  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      hit1[i] = valid_q[i] && bus.cdb_en_i && (bus.cdb_tag_i == prs1_q[i]);
      hit2[i] = valid_q[i] && bus.cdb_en_i && (bus.cdb_tag_i == prs2_q[i]);
    end
  end

`ifdef RS_SAME_CYCLE_WAKEUP_EN
  assign sel_rdy1 = rdy1_q | hit1;
  assign sel_rdy2 = rdy2_q | hit2;
`else
  assign sel_rdy1 = rdy1_q;
  assign sel_rdy2 = rdy2_q;
`endif

  assign cand = valid_q & sel_rdy1 & sel_rdy2;

  // Oldest candidate: no other candidate is marked older than it
  logic pick_found;
  idx_t pick_idx;
  logic blocked;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    blocked    = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (cand[j] && older_q[j][i]) blocked = 1'b1;
      end
      if (cand[i] && !blocked && !pick_found) begin
        pick_found = 1'b1;
        pick_idx   = idx_t'(i);
      end
    end
  end

  // A stalled presentation is pinned so the FU sees a stable payload
  logic issue_vld;
  idx_t sel_idx;
  assign sel_idx   = lock_q ? lock_idx_q : pick_idx;
  assign issue_vld = lock_q ? valid_q[lock_idx_q] : pick_found;

  // Lowest-index free slot for allocation
  idx_t free_idx;
  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = idx_t'(i);
    end
  end

  logic [CNT_W-1:0] count;
  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      count = count + CNT_W'(valid_q[i]);
    end
  end

  // Readiness depends only on registered occupancy: an issue fire in the
  // same cycle does not free a slot for allocation.
  logic alloc_ready, alloc_fire, issue_fire;
  assign alloc_ready = ~&valid_q;
  assign alloc_fire  = bus.alloc_valid_i && alloc_ready;
  assign issue_fire  = issue_vld && bus.issue_ready_i;

  logic new_rdy1, new_rdy2;
  assign new_rdy1 = bus.alloc_prs1_valid_i || (bus.alloc_prs1_addr_i == '0) ||
                    (bus.cdb_en_i && (bus.cdb_tag_i == bus.alloc_prs1_addr_i));
  assign new_rdy2 = bus.alloc_prs2_valid_i || (bus.alloc_prs2_addr_i == '0) ||
                    (bus.cdb_en_i && (bus.cdb_tag_i == bus.alloc_prs2_addr_i));

  // Control state update; flush acts as reset and overrides everything
  always_ff @(posedge clk_i) begin
    if (reset_i || bus.flush_i) begin
      valid_q    <= '0;
      rdy1_q     <= '0;
      rdy2_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) older_q[i] <= '0;
    end else begin
      rdy1_q <= rdy1_q | hit1;
      rdy2_q <= rdy2_q | hit2;

      if (alloc_fire) begin
        valid_q[free_idx] <= 1'b1;
        rdy1_q[free_idx]  <= new_rdy1;
        rdy2_q[free_idx]  <= new_rdy2;
        older_q[free_idx] <= '0;
        for (int j = 0; j < NUM_ENTRIES; j++) older_q[j][free_idx] <= valid_q[j];
      end

      // Issue clear comes after alloc so it wins on the shared matrix bits
      if (issue_fire) begin
        valid_q[sel_idx] <= 1'b0;
        older_q[sel_idx] <= '0;
        for (int j = 0; j < NUM_ENTRIES; j++) older_q[j][sel_idx] <= 1'b0;
        lock_q <= 1'b0;
      end else if (issue_vld) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel_idx;
      end
    end
  end

  // Payload capture
  always_ff @(posedge clk_i) begin
    if (alloc_fire) begin
      pc_q[free_idx]   <= bus.alloc_pc_i;
      inst_q[free_idx] <= bus.alloc_inst_i;
      prs1_q[free_idx] <= bus.alloc_prs1_addr_i;
      prs2_q[free_idx] <= bus.alloc_prs2_addr_i;
      prd_q[free_idx]  <= bus.alloc_prd_addr_i;
    end
  end

  // Outputs; payload is zeroed while nothing is presented
  assign bus.alloc_ready_o     = alloc_ready;
  assign bus.count_o           = count;
  assign bus.issue_valid_o     = issue_vld;
  assign bus.issue_pc_o        = issue_vld ? pc_q[sel_idx]   : '0;
  assign bus.issue_inst_o      = issue_vld ? inst_q[sel_idx] : '0;
  assign bus.issue_prs1_addr_o = issue_vld ? prs1_q[sel_idx] : '0;
  assign bus.issue_prs2_addr_o = issue_vld ? prs2_q[sel_idx] : '0;
  assign bus.issue_prd_addr_o  = issue_vld ? prd_q[sel_idx]  : '0;

endmodule

// File: tb/tb_rs_issue_sched.sv
`timescale 1ns/1ps
module tb_rs_issue_sched;
  localparam int N     = 4;
  localparam int TAG_W = 5;
  localparam int CNT_W = $clog2(N + 1);
`ifdef RS_SAME_CYCLE_WAKEUP_EN
  localparam bit SAME = 1'b1;
`else
  localparam bit SAME = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_issue_sched_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bus();

  rs_issue_sched #(.NUM_ENTRIES(N), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  // Reference model: list of live instructions, oldest first
  typedef struct {
    int               id;
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [TAG_W-1:0] s1, s2, d;
    bit               r1, r2;
  } ent_t;

  ent_t q[$];
  int   lock_id  = -1;
  int   next_id  = 0;
  int   exp_pos  = -1;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cdb_hit(input logic [TAG_W-1:0] t);
    return bus.cdb_en_i && (bus.cdb_tag_i == t);
  endfunction

  task automatic drive(input bit av, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [TAG_W-1:0] s1, input logic [TAG_W-1:0] s2,
                       input logic [TAG_W-1:0] d, input bit v1, input bit v2,
                       input bit ce, input logic [TAG_W-1:0] ct, input bit ir, input bit fl);
    bus.alloc_valid_i      = av;
    bus.alloc_pc_i         = pc;
    bus.alloc_inst_i       = inst;
    bus.alloc_prs1_addr_i  = s1;
    bus.alloc_prs2_addr_i  = s2;
    bus.alloc_prd_addr_i   = d;
    bus.alloc_prs1_valid_i = v1;
    bus.alloc_prs2_valid_i = v2;
    bus.cdb_en_i           = ce;
    bus.cdb_tag_i          = ct;
    bus.issue_ready_i      = ir;
    bus.flush_i            = fl;
  endtask

  task automatic idle(input bit ir);
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, ir, 1'b0);
  endtask

  // Before the edge: predict presented entry and compare all outputs
  task automatic sample();
    bit v;
    @(negedge clk);
    exp_pos = -1;
    if (lock_id >= 0) begin
      foreach (q[p]) if (q[p].id == lock_id) exp_pos = p;
    end else begin
      foreach (q[p]) begin
        if (exp_pos < 0 &&
            (q[p].r1 || (SAME && cdb_hit(q[p].s1))) &&
            (q[p].r2 || (SAME && cdb_hit(q[p].s2))))
          exp_pos = p;
      end
    end
    v = (exp_pos >= 0);
    if (!rst) begin
      chk("issue_valid", 32'(bus.issue_valid_o), 32'(v));
      chk("alloc_ready", 32'(bus.alloc_ready_o), 32'(q.size() < N));
      chk("count", 32'(bus.count_o), 32'(q.size()));
      chk("issue_pc", bus.issue_pc_o, v ? q[exp_pos].pc : 32'h0);
      chk("issue_inst", bus.issue_inst_o, v ? q[exp_pos].inst : 32'h0);
      chk("issue_prs1", 32'(bus.issue_prs1_addr_o), v ? 32'(q[exp_pos].s1) : 32'h0);
      chk("issue_prs2", 32'(bus.issue_prs2_addr_o), v ? 32'(q[exp_pos].s2) : 32'h0);
      chk("issue_prd", 32'(bus.issue_prd_addr_o), v ? 32'(q[exp_pos].d) : 32'h0);
    end
  endtask

  // At the edge: apply alloc / wakeup / issue / flush to the model
  task automatic commit();
    bit   alloc_ok;
    ent_t e;
    @(posedge clk);
    if (rst || bus.flush_i) begin
      q.delete();
      lock_id = -1;
    end else begin
      alloc_ok = bus.alloc_valid_i && (q.size() < N);
      foreach (q[p]) begin
        if (cdb_hit(q[p].s1)) q[p].r1 = 1'b1;
        if (cdb_hit(q[p].s2)) q[p].r2 = 1'b1;
      end
      if (exp_pos >= 0 && bus.issue_ready_i) begin
        q.delete(exp_pos);
        lock_id = -1;
      end else if (exp_pos >= 0) begin
        lock_id = q[exp_pos].id;
      end
      if (alloc_ok) begin
        e.id   = next_id++;
        e.pc   = bus.alloc_pc_i;
        e.inst = bus.alloc_inst_i;
        e.s1   = bus.alloc_prs1_addr_i;
        e.s2   = bus.alloc_prs2_addr_i;
        e.d    = bus.alloc_prd_addr_i;
        e.r1   = bus.alloc_prs1_valid_i || (e.s1 == 0) || cdb_hit(e.s1);
        e.r2   = bus.alloc_prs2_valid_i || (e.s2 == 0) || cdb_hit(e.s2);
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic step();
    sample();
    commit();
  endtask

  initial begin
    rst = 1'b1;
    idle(1'b0);
    step();
    step();
    rst = 1'b0;

    // Reset state
    sample();
    chk("rst_valid", 32'(bus.issue_valid_o), 32'h0);
    chk("rst_count", 32'(bus.count_o), 32'h0);
    chk("rst_alloc_ready", 32'(bus.alloc_ready_o), 32'h1);
    commit();

    // Single ready add issues the next cycle
    drive(1'b1, 32'h0, 32'h003100b3, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    step();
    idle(1'b1);
    sample();
    chk("add_valid", 32'(bus.issue_valid_o), 32'h1);
    chk("add_inst", bus.issue_inst_o, 32'h003100b3);
    chk("add_prd", 32'(bus.issue_prd_addr_o), 32'h1);
    chk("add_count", 32'(bus.count_o), 32'h1);
    commit();
    step();

    // Younger ready entry bypasses older waiting one; wakeup then issues it
    drive(1'b1, 32'h100, 32'h11, 5'd5, 5'd6, 5'd10, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h104, 32'h12, 5'd3, 5'd4, 5'd11, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    step();
    idle(1'b1);
    sample();
    chk("b_first_prd", 32'(bus.issue_prd_addr_o), 32'd11);
    commit();
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
    sample();
    chk("a_wake_cycle_valid", 32'(bus.issue_valid_o), SAME ? 32'h1 : 32'h0);
    commit();
    idle(1'b1);
    sample();
    chk("a_after_wake_valid", 32'(bus.issue_valid_o), SAME ? 32'h0 : 32'h1);
    commit();

    // Fill with stalled FU, then drain in allocation order
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h200 + 32'(4 * k), 32'h20 + 32'(k), 5'd1, 5'd2, 5'(12 + k),
            1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      step();
    end
    idle(1'b0);
    sample();
    chk("full_alloc_ready", 32'(bus.alloc_ready_o), 32'h0);
    chk("full_count", 32'(bus.count_o), 32'd4);
    commit();
    for (int k = 0; k < 4; k++) begin
      drive(k == 0, 32'h300, 32'h30, 5'd1, 5'd1, 5'd30, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      sample();
      chk("drain_order_pc", bus.issue_pc_o, 32'h200 + 32'(4 * k));
      commit();
    end
    idle(1'b1);
    step();

    // Lock holds younger C while older D wakes
    drive(1'b1, 32'h400, 32'h40, 5'd9, 5'd1, 5'd20, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h404, 32'h41, 5'd1, 5'd2, 5'd21, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    step();
    idle(1'b0);
    sample();
    chk("c_presented", 32'(bus.issue_prd_addr_o), 32'd21);
    commit();
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    sample();
    chk("c_held_on_wake", 32'(bus.issue_prd_addr_o), 32'd21);
    commit();
    idle(1'b0);
    sample();
    chk("c_held", 32'(bus.issue_prd_addr_o), 32'd21);
    commit();
    idle(1'b1);
    sample();
    chk("c_fire", 32'(bus.issue_prd_addr_o), 32'd21);
    commit();
    sample();
    chk("d_next", 32'(bus.issue_prd_addr_o), 32'd20);
    commit();

    // CDB broadcast in the allocation cycle; prs1 = 0 counts as ready
    drive(1'b1, 32'h500, 32'h50, 5'd0, 5'd7, 5'd22, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
    step();
    idle(1'b1);
    sample();
    chk("cdb_alloc_valid", 32'(bus.issue_valid_o), 32'h1);
    chk("cdb_alloc_prd", 32'(bus.issue_prd_addr_o), 32'd22);
    commit();

    // Flush with three entries and a concurrent alloc
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h600 + 32'(4 * k), 32'h60, 5'd1, 5'd2, 5'(23 + k),
            1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h700, 32'h70, 5'd1, 5'd2, 5'd26, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
    step();
    idle(1'b0);
    sample();
    chk("flush_count", 32'(bus.count_o), 32'h0);
    chk("flush_valid", 32'(bus.issue_valid_o), 32'h0);
    chk("flush_alloc_ready", 32'(bus.alloc_ready_o), 32'h1);
    commit();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      drive(($urandom % 3) != 0, $urandom, $urandom,
            5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 32),
            $urandom % 2 == 0, $urandom % 2 == 0,
            $urandom % 2 == 0, 5'($urandom % 8),
            ($urandom % 4) != 0, ($urandom % 50) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_issue_sched.md
Name: rs_issue_sched

Overview:
- Per-functional-unit issue scheduler for one reservation-station class (ALU, MUL or LSU); one instance per FU class.
- Holds up to NUM_ENTRIES decoded instructions and wakes source operands from CDB broadcasts.
- Selects the oldest fully-ready entry and hands it to its FU over a valid/ready handshake.
- Sits between rename/dispatch and the FU; drives the per-class free signal used to stall fetch/decode.

Parameters:
- NUM_ENTRIES, 4, number of scheduler slots (≥2)
- TAG_W, 5, physical register tag width
- CNT_W, $clog2(NUM_ENTRIES+1), width of count_o

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- reset_i  input  1  synchronous, active-high reset
- flush_i  input  1  discard all entries (branch mispredict)
- alloc_valid_i  input  1  dispatch offers an instruction
- alloc_ready_o  output  1  slot available; alloc fires when alloc_valid_i && alloc_ready_o
- alloc_pc_i  input  32  instruction PC
- alloc_inst_i  input  32  instruction word
- alloc_prs1_addr_i  input  TAG_W  source 1 tag
- alloc_prs2_addr_i  input  TAG_W  source 2 tag
- alloc_prd_addr_i  input  TAG_W  destination tag
- alloc_prs1_valid_i  input  1  source 1 already available
- alloc_prs2_valid_i  input  1  source 2 already available
- cdb_en_i  input  1  CDB broadcast valid
- cdb_tag_i  input  TAG_W  broadcast destination tag
- issue_valid_o  output  1  selected entry presented to FU
- issue_ready_i  input  1  FU accepts; issue fires when both high
- issue_pc_o  output  32  selected PC
- issue_inst_o  output  32  selected instruction
- issue_prs1_addr_o  output  TAG_W  selected source 1 tag
- issue_prs2_addr_o  output  TAG_W  selected source 2 tag
- issue_prd_addr_o  output  TAG_W  selected destination tag
- count_o  output  CNT_W  occupied entries

Behaviour:
- Per-slot state: valid, rdy1, rdy2, payload; an NxN age matrix older[j][i] means slot j is older than slot i.
- Reset (synchronous, reset_i=1 at clock edge):
  - all slots invalid, lock cleared
  - issue_valid_o=0, count_o=0, alloc_ready_o=1
  - issue payload outputs drive 0 whenever issue_valid_o=0
- alloc_ready_o = (count_o < NUM_ENTRIES), from registered state only. An issue fire in the same cycle does not free a slot for allocation; full plus issue still gives alloc_ready_o=0.
- Allocation fire:
  - write lowest-index free slot k
  - rdyN = alloc_prsN_valid_i OR (prsN==0) OR (cdb_en_i AND cdb_tag_i==prsN)
  - older[j][k]=1 for every currently valid j, older[k][*]=0
- Wakeup: each valid slot with cdb_en_i && cdb_tag_i==prsN sets rdyN at the clock edge; the entry is selectable the following cycle (baseline).
- Select: candidates are valid && rdy1 && rdy2. Pick the candidate i with no other candidate j having older[j][i]=1.
- Lock: once issue_valid_o=1 and issue_ready_i=0, the selected index is registered and held. Payload and issue_valid_o stay stable until fire or flush, even if an older entry wakes meanwhile. The lock releases on fire.
- Issue fire: selected slot invalidated at the edge, its age-matrix column and row cleared. Latency from ready to issue_valid_o is 0 cycles (combinational select from registered state). Sustained throughput is 1 issue/cycle.
- Simultaneous alloc + issue fire: both take effect; count_o unchanged.
- Simultaneous CDB wakeup and issue of a different slot: both take effect.
- flush_i: same effect as reset at the edge and has priority over alloc, issue and wakeup. issue_valid_o may be 1 during the flush cycle; the FU ignores an issue fire in a flush cycle.
- count_o is never more than NUM_ENTRIES. Wrap-around is not possible because slots are a bitmap, not a circular pointer.

Optional Feature:
- Macro RS_SAME_CYCLE_WAKEUP_EN.
- Defined: the CDB match is ORed combinationally into rdy1/rdy2 for select, so an entry woken in cycle N may present issue_valid_o in cycle N. The lock rule still applies.
- Undefined: the woken entry is first selectable in cycle N+1.

Test Plan:
- Reset, then allocate add (pc=0, inst=0x003100b3, prs1=2, prs2=3, prd=1, both valid) with issue_ready_i=1 -> issue_valid_o=1 the next cycle with issue_inst_o=0x003100b3, prd=1; count_o goes 1→0.
- Allocate A (prs1=5 not valid) then B (ready) -> B issues first. Then cdb_en_i=1, tag=5 -> A issues one cycle later (same cycle if RS_SAME_CYCLE_WAKEUP_EN).
- Allocate 4 ready entries with issue_ready_i=0 -> alloc_ready_o=0, count_o=4. Raise issue_ready_i -> entries issue in allocation order, one per cycle.
- Hold issue_ready_i=0 with younger C presented, then wake older D -> issue outputs stay on C until fire, then D issues.
- Allocation in the same cycle as a CDB broadcast of its prs2 tag=7 -> entry issues without a further broadcast; prs=0 is treated as ready.
- flush_i with 3 entries plus a concurrent alloc -> next cycle count_o=0, issue_valid_o=0, alloc_ready_o=1.
